// File: rtl/req_master.sv
// Initiator side of a four-phase req/ack word transfer, fed by a small command FIFO.
// Optional feature: define REQ_MASTER_RETRY_EN to re-issue timed-out words up to MAX_RETRIES times.
module req_master #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned MAX_RETRIES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cmd_ready,
   output logic              req,
   output logic [DATA_W-1:0] data,
   input  logic              ack,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [15:0]       sent_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2 ||
       MAX_RETRIES > 255) begin : g_param_check
      $error("req_master: illegal parameter value");
   end

   typedef enum logic [1:0] {StIdle, StReq, StRel} state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                done_q, done_d;
   logic                terr_q, terr_d;
   logic [15:0]         sent_q, sent_d;
   logic [TW-1:0]       timer_q, timer_d;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         count_q;
   logic                push, pop;

`ifdef REQ_MASTER_RETRY_EN
   localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   logic [RW-1:0]       retries_q, retries_d;
   // Set by a retryable timeout: the next S_IDLE re-issues data_q instead of popping.
   logic                reissue_q, reissue_d;
`endif

   assign cmd_ready = (count_q != (AW + 1)'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state_q != StIdle) || (count_q != '0);

   assign req         = req_q;
   assign data        = data_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign sent_count  = sent_q;

   // Storage is not reset; the pointers alone define what is queued.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      terr_d  = 1'b0;
      sent_d  = sent_q;
      timer_d = timer_q;
      pop     = 1'b0;
`ifdef REQ_MASTER_RETRY_EN
      retries_d = retries_q;
      reissue_d = reissue_q;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef REQ_MASTER_RETRY_EN
            if (reissue_q) begin
               req_d     = 1'b1;
               timer_d   = '0;
               reissue_d = 1'b0;
               state_d   = StReq;
            end else
`endif
            if (count_q != '0) begin
               pop     = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               req_d   = 1'b1;
               timer_d = '0;
`ifdef REQ_MASTER_RETRY_EN
               retries_d = '0;
`endif
               state_d = StReq;
            end
         end
         StReq: begin
            if (ack) begin
               req_d   = 1'b0;
               done_d  = 1'b1;
               sent_d  = sent_q + 16'd1;
               state_d = StRel;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               state_d = StRel;
`ifdef REQ_MASTER_RETRY_EN
               if (retries_q < RW'(MAX_RETRIES)) begin
                  retries_d = retries_q + 1'b1;
                  reissue_d = 1'b1;
               end else begin
                  terr_d = 1'b1;
               end
`else
               terr_d = 1'b1;
`endif
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StRel: begin
            if (!ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
         sent_q  <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
         sent_q  <= sent_d;
         timer_q <= timer_d;
      end
   end

`ifdef REQ_MASTER_RETRY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retries_q <= '0;
         reissue_q <= 1'b0;
      end else begin
         retries_q <= retries_d;
         reissue_q <= reissue_d;
      end
   end
`endif

endmodule

// File: tb/tb_req_master.sv
// Directed bench for req_master: responder model, event monitor, immediate-assert checks.
// Retry scenarios are selected by REQ_MASTER_RETRY_EN, matching the DUT build.
module tb_req_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [31:0] cmd_data = '0;
   logic        cmd_ready;
   logic        req;
   logic [31:0] data;
   logic        ack;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic [15:0] sent_count;

   int checks = 0;
   int errors = 0;

   // 0: ack = req delayed one cycle, 1: dead, 2: ack only from the 2nd attempt on
   int ack_mode = 0;
   int r_base = 0;

   int          cyc = 0;
   int          rises = 0;
   int          falls = 0;
   int          hi_len = 0;
   int          terr_count = 0;
   int          terr_at_fall = 0;
   int          done_count = 0;
   logic        req_prev = 1'b0;
   logic [31:0] rise_data [64];
   int          rise_cyc [64];
   int          fall_len [64];

   int r0, f0, t0, d0;

   req_master dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .req         (req),
      .data        (data),
      .ack         (ack),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .sent_count  (sent_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack <= 1'b0;
      else begin
         case (ack_mode)
            0:       ack <= req;
            1:       ack <= 1'b0;
            default: ack <= req && ((rises - r_base) >= 2);
         endcase
      end
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (req && !req_prev) begin
         rise_data[rises % 64] = data;
         rise_cyc[rises % 64]  = cyc;
         rises  = rises + 1;
         hi_len = 0;
      end
      if (req) hi_len = hi_len + 1;
      if (!req && req_prev) begin
         fall_len[falls % 64] = hi_len;
         falls = falls + 1;
      end
      if (timeout_err) begin
         terr_count   = terr_count + 1;
         terr_at_fall = falls;
      end
      if (done) done_count = done_count + 1;
      req_prev = req;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      r0 = rises;
      f0 = falls;
      t0 = terr_count;
      d0 = done_count;
   endtask

   initial begin
      // Reset values
      tick(2);
      check("rst_req", 32'(req), 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_terr", 32'(timeout_err), 32'd0);
      check("rst_sent", 32'(sent_count), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick(1);

      // 1: single word latency
      snap();
      cmd_valid = 1'b1;
      cmd_data  = 32'hDEADBEEF;
      tick(1);
      cmd_valid = 1'b0;
      check("t1_e0_req", 32'(req), 32'd0);
      check("t1_e0_busy", 32'(busy), 32'd1);
      tick(1);
      check("t1_e1_req", 32'(req), 32'd1);
      check("t1_e1_data", data, 32'hDEADBEEF);
      tick(1);
      check("t1_e2_req", 32'(req), 32'd1);
      tick(1);
      check("t1_e3_req", 32'(req), 32'd0);
      check("t1_e3_done", 32'(done), 32'd1);
      check("t1_e3_sent", 32'(sent_count), 32'd1);
      tick(1);
      check("t1_e4_done", 32'(done), 32'd0);
      check("t1_e4_busy", 32'(busy), 32'd1);
      tick(1);
      check("t1_e5_busy", 32'(busy), 32'd0);
      check("t1_done_cnt", 32'(done_count - d0), 32'd1);

      // 2: back-to-back words, FIFO fills to 4
      snap();
      for (int i = 1; i <= 5; i++) begin
         cmd_valid = 1'b1;
         cmd_data  = 32'(i);
         tick(1);
      end
      cmd_valid = 1'b0;
      check("t2_full_ready", 32'(cmd_ready), 32'd0);
      tick(40);
      check("t2_rises", 32'(rises - r0), 32'd5);
      for (int i = 0; i < 5; i++) check("t2_order", rise_data[(r0 + i) % 64], 32'(i + 1));
      for (int i = 0; i < 4; i++)
         check("t2_spacing", 32'(rise_cyc[(r0 + i + 1) % 64] - rise_cyc[(r0 + i) % 64]), 32'd5);
      check("t2_sent", 32'(sent_count), 32'd6);
      check("t2_done_cnt", 32'(done_count - d0), 32'd5);
      check("t2_busy", 32'(busy), 32'd0);

`ifdef REQ_MASTER_RETRY_EN
      // 4: dead responder, two retries then abandon
      ack_mode = 1;
      snap();
      cmd_valid = 1'b1;
      cmd_data  = 32'h0B0B0001;
      tick(1);
      cmd_valid = 1'b0;
      tick(80);
      check("t4_rises", 32'(rises - r0), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("t4_data", rise_data[(r0 + i) % 64], 32'h0B0B0001);
         check("t4_len", 32'(fall_len[(f0 + i) % 64]), 32'd16);
      end
      check("t4_terr_cnt", 32'(terr_count - t0), 32'd1);
      check("t4_terr_when", 32'(terr_at_fall - f0), 32'd3);
      check("t4_done_cnt", 32'(done_count - d0), 32'd0);
      check("t4_sent", 32'(sent_count), 32'd6);

      // 5: responder acks only on the second attempt
      ack_mode = 2;
      snap();
      r_base = rises;
      cmd_valid = 1'b1;
      cmd_data  = 32'h0C0C0001;
      tick(1);
      cmd_valid = 1'b0;
      tick(60);
      check("t5_rises", 32'(rises - r0), 32'd2);
      check("t5_data0", rise_data[r0 % 64], 32'h0C0C0001);
      check("t5_data1", rise_data[(r0 + 1) % 64], 32'h0C0C0001);
      check("t5_len0", 32'(fall_len[f0 % 64]), 32'd16);
      check("t5_terr_cnt", 32'(terr_count - t0), 32'd0);
      check("t5_done_cnt", 32'(done_count - d0), 32'd1);
      check("t5_sent", 32'(sent_count), 32'd7);
      check("t5_busy", 32'(busy), 32'd0);
`else
      // 3: dead responder, each word abandoned after 16 cycles
      ack_mode = 1;
      snap();
      cmd_valid = 1'b1;
      cmd_data  = 32'h0A0A0001;
      tick(1);
      cmd_data  = 32'h0A0A0002;
      tick(1);
      cmd_valid = 1'b0;
      tick(60);
      check("t3_rises", 32'(rises - r0), 32'd2);
      check("t3_data0", rise_data[r0 % 64], 32'h0A0A0001);
      check("t3_data1", rise_data[(r0 + 1) % 64], 32'h0A0A0002);
      check("t3_len0", 32'(fall_len[f0 % 64]), 32'd16);
      check("t3_len1", 32'(fall_len[(f0 + 1) % 64]), 32'd16);
      check("t3_terr_cnt", 32'(terr_count - t0), 32'd2);
      check("t3_terr_when", 32'(terr_at_fall - f0), 32'd2);
      check("t3_done_cnt", 32'(done_count - d0), 32'd0);
      check("t3_sent", 32'(sent_count), 32'd6);
      check("t3_busy", 32'(busy), 32'd0);
`endif

      // 6: reset during S_REQ with three words queued
      ack_mode = 1;
      for (int i = 1; i <= 4; i++) begin
         cmd_valid = 1'b1;
         cmd_data  = 32'hD0D00000 + 32'(i);
         tick(1);
      end
      cmd_valid = 1'b0;
      tick(3);
      check("t6_req_before", 32'(req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_req_async", 32'(req), 32'd0);
      tick(1);
      rst_n = 1'b1;
      snap();
      tick(1);
      check("t6_ready", 32'(cmd_ready), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      tick(20);
      check("t6_no_req", 32'(rises - r0), 32'd0);
      check("t6_sent", 32'(sent_count), 32'd0);
      check("t6_busy_late", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
